// File: rtl/word_load_pkg.sv
// Shared types and constants for the word load sequencer.
// The slot count is tied to the width of the downstream 3-to-8 decoder.
package word_load_pkg;

    localparam int SLOT_IDX_W = 3;
    localparam int NUM_SLOTS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/word_load_sequencer_if.sv
// Handshake and write-port bundle between upstream, word_load_sequencer and the decoder/bank.
// frame_err exists only when WORD_LOAD_LAST_CHECK_EN is defined.
interface word_load_sequencer_if #(
    parameter int DATA_W = 32
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              abort;
    logic              done_ack;
    logic [2:0]        sel;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic              busy;
`ifdef WORD_LOAD_LAST_CHECK_EN
    logic              frame_err;
`endif

    modport master (
        output in_valid, in_data, in_last, abort, done_ack,
        input  in_ready, sel, wr_en, wr_data, frame_done, busy
`ifdef WORD_LOAD_LAST_CHECK_EN
        , input frame_err
`endif
    );

    modport slave (
        input  in_valid, in_data, in_last, abort, done_ack,
        output in_ready, sel, wr_en, wr_data, frame_done, busy
`ifdef WORD_LOAD_LAST_CHECK_EN
        , output frame_err
`endif
    );

endinterface

// File: rtl/slot_index_counter.sv
// Slot index counter: clear has priority over increment; wrap flags the 7->0 step.
module slot_index_counter
    import word_load_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  inc,
    input  logic                  clr,
    output logic [SLOT_IDX_W-1:0] idx,
    output logic                  wrap
);

    logic [SLOT_IDX_W-1:0] idx_d, idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_q + SLOT_IDX_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    assign wrap = inc && !clr && (idx_q == SLOT_IDX_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/word_load_sequencer.sv
// Assigns slot indices 0..7 to incoming words and presents registered writes to the decoder.
// Optional in_last consistency check enabled by WORD_LOAD_LAST_CHECK_EN.
module word_load_sequencer
    import word_load_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_SLOTS = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    word_load_sequencer_if.slave  bus
);

    if (NUM_SLOTS != word_load_pkg::NUM_SLOTS) begin : g_bad_num_slots
        $error("word_load_sequencer: NUM_SLOTS must be 8 to match the 3-bit decoder");
    end

    state_e                state_d, state_q;
    logic [SLOT_IDX_W-1:0] sel_d, sel_q;
    logic                  wr_en_d, wr_en_q;
    logic [DATA_W-1:0]     wr_data_d, wr_data_q;
    logic                  frame_done_d, frame_done_q;
    logic                  busy_d, busy_q;

    logic                  in_ready;
    logic                  accept;
    logic [SLOT_IDX_W-1:0] idx;
    logic                  wrap;

    // abort blocks acceptance in the same cycle so no word is half-taken
    assign in_ready = (state_q != DONE) && !bus.abort;
    assign accept   = bus.in_valid && in_ready;

    slot_index_counter u_idx (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (accept),
        .clr     (bus.abort),
        .idx     (idx),
        .wrap    (wrap)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;

        if (accept) begin
            sel_d     = idx;
            wr_data_d = bus.in_data;
            wr_en_d   = 1'b1;
        end

        unique case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    if (wrap) state_d = DONE;
            DONE:    if (bus.done_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.abort) begin
            state_d = IDLE;
        end

        frame_done_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

`ifdef WORD_LOAD_LAST_CHECK_EN
    logic frame_err_d, frame_err_q;
    logic last_mismatch;

    assign last_mismatch = bus.in_last != (idx == SLOT_IDX_W'(NUM_SLOTS - 1));

    // first word of a frame restarts the error history
    always_comb begin
        frame_err_d = frame_err_q;
        if (bus.abort) begin
            frame_err_d = 1'b0;
        end else if (accept) begin
            frame_err_d = (state_q == IDLE) ? last_mismatch : (frame_err_q | last_mismatch);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    logic unused_in_last;
    assign unused_in_last = bus.in_last;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.sel        = sel_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule
